// File: rtl/dot_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_pipe_if
// Brief    : Upstream-FIFO / downstream-FIFO bundle for the pipelined dot unit.
//            sat_flag is present only when DOT_PIPE_SATURATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface dot_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 3
);
  logic [N-1:0][DATA_WIDTH-1:0] x;
  logic [N-1:0][DATA_WIDTH-1:0] y;
  logic                         in_empty;
  logic                         in_rd_en;
  logic [DATA_WIDTH-1:0]        out;
  logic                         out_full;
  logic                         out_wr_en;
`ifdef DOT_PIPE_SATURATE_EN
  logic                         sat_flag;
`endif

  // Environment side: owns both FIFOs
  modport master (
    output x, y, in_empty, out_full,
    input  in_rd_en, out, out_wr_en
`ifdef DOT_PIPE_SATURATE_EN
    , input sat_flag
`endif
  );

  // Dot unit side
  modport slave (
    input  x, y, in_empty, out_full,
    output in_rd_en, out, out_wr_en
`ifdef DOT_PIPE_SATURATE_EN
    , output sat_flag
`endif
  );
endinterface
`default_nettype wire

// File: rtl/dot_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dot_pipe
// Brief    : Fully pipelined signed fixed-point dot product, one vector/cycle.
//            Stage A: N full-width products. Stage B: reduced, narrowed sum.
//            Build option DOT_PIPE_SATURATE_EN: clamp instead of wrap and
//            expose a registered sat_flag.
// Revision : 1.0 - initial release
// ============================================================================
module dot_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 10,
  parameter int N          = 3
) (
  input  wire logic clock,
  input  wire logic reset,
  dot_pipe_if.slave bus
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(N);

  logic signed [PROD_W-1:0] prod_a [N];
  logic signed [PROD_W-1:0] prod_d [N];
  logic                     va;
  logic                     vb;
  logic [DATA_WIDTH-1:0]    out_q;
  logic                     advance;
  logic                     rd_en;
  logic signed [SUM_W-1:0]  sum;
  logic [DATA_WIDTH-1:0]    out_d;

  // Both stages move together whenever stage B is empty or can drain.
  // Handshakes depend only on flags and FIFO status, never on operand data.
  assign advance       = !vb || !bus.out_full;
  assign rd_en         = !reset && !bus.in_empty && advance;
  assign bus.in_rd_en  = rd_en;
  assign bus.out_wr_en = !reset && vb && !bus.out_full;
  assign bus.out       = out_q;

  // Exact signed products, sign-extended to double width before multiplying
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod_d[i] = PROD_W'($signed(bus.x[i])) * PROD_W'($signed(bus.y[i]));
    end
  end

  // Floor-shift each product, then accumulate with headroom for N terms
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + SUM_W'(prod_a[i] >>> Q_BITS);
    end
  end

`ifdef DOT_PIPE_SATURATE_EN
  localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic sat_d;
  logic sat_q;

  assign bus.sat_flag = sat_q;

  // Clamp the wide sum into the signed output range, flagging any clamp
  always_comb begin
    out_d = sum[DATA_WIDTH-1:0];
    sat_d = 1'b0;
    if (sum > MAX_V) begin
      out_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_d = 1'b1;
    end else if (sum < MIN_V) begin
      out_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat_d = 1'b1;
    end
  end
`else
  // Upper sum bits are deliberately discarded by two's-complement wrap
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[SUM_W-1:DATA_WIDTH];

  // Wrap narrowing: keep the low result bits
  always_comb begin
    out_d = sum[DATA_WIDTH-1:0];
  end
`endif

  // Two-stage pipeline registers; everything holds when advance is low
  always_ff @(posedge clock) begin
    if (reset) begin
      va    <= 1'b0;
      vb    <= 1'b0;
      out_q <= '0;
      for (int i = 0; i < N; i++) begin
        prod_a[i] <= '0;
      end
`ifdef DOT_PIPE_SATURATE_EN
      sat_q <= 1'b0;
`endif
    end else if (advance) begin
      va <= rd_en;
      vb <= va;
      if (rd_en) begin
        for (int i = 0; i < N; i++) begin
          prod_a[i] <= prod_d[i];
        end
      end
      if (va) begin
        out_q <= out_d;
`ifdef DOT_PIPE_SATURATE_EN
        sat_q <= sat_d;
`endif
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dot_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_pipe
// Brief    : Scoreboard bench for dot_pipe (DATA_WIDTH=32, Q_BITS=10, N=3).
//            Expected results are queued when an operand pair is popped and
//            compared by an independent monitor whenever out_wr_en is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_pipe;
  localparam int DW = 32;
  localparam int QB = 10;
  localparam int NN = 3;

  typedef struct packed {
    logic [NN-1:0][DW-1:0] x;
    logic [NN-1:0][DW-1:0] y;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] out;
    logic          sat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   bubble_pct = 0;
  int   full_pct   = 0;
  vec_t src[$];
  exp_t sb[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  dot_pipe_if #(.DATA_WIDTH(DW), .N(NN)) bus ();

  dot_pipe #(.DATA_WIDTH(DW), .Q_BITS(QB), .N(NN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual='h%0h expected='h%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: floor(x*y / 2^Q) per channel, exact sum, then wrap or clamp
  function automatic exp_t model(input vec_t v);
    longint acc;
    longint lim;
    exp_t   e;
    acc = 0;
    lim = 64'sd2147483647;
    for (int i = 0; i < NN; i++) begin
      acc += (longint'($signed(v.x[i])) * longint'($signed(v.y[i]))) >>> QB;
    end
    e.sat = 1'b0;
    e.out = acc[DW-1:0];
`ifdef DOT_PIPE_SATURATE_EN
    if (acc > lim) begin
      e.out = 32'h7FFF_FFFF;
      e.sat = 1'b1;
    end else if (acc < -lim - 1) begin
      e.out = 32'h8000_0000;
      e.sat = 1'b1;
    end
`endif
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    logic [DW-1:0] edges [5];
    edges[0] = 32'h8000_0000;
    edges[1] = 32'h7FFF_FFFF;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h4000_0000;
    edges[4] = 32'h0000_0000;
    case ($urandom_range(0, 2))
      0:       return $urandom();
      1:       return DW'($signed($urandom_range(0, 8191)) - 4096);
      default: return edges[$urandom_range(0, 4)];
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < NN; i++) begin
      v.x[i] = rand_elem();
      v.y[i] = rand_elem();
    end
    return v;
  endfunction

  function automatic vec_t mk_vec(input int x0, input int x1, input int x2,
                                  input int y0, input int y1, input int y2);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2;
    return v;
  endfunction

  // One cycle: drive FIFO status at negedge, then act on the settled handshake
  task automatic step(input bit rst_v);
    @(negedge clock);
    reset        = rst_v;
    bus.in_empty = (src.size() == 0) || ($urandom_range(0, 99) < bubble_pct);
    if (src.size() != 0) begin
      bus.x = src[0].x;
      bus.y = src[0].y;
    end
    bus.out_full = ($urandom_range(0, 99) < full_pct);
    #1;
    if (rst_v) begin
      check("rst_rd_en", 64'(bus.in_rd_en), 64'd0);
      check("rst_wr_en", 64'(bus.out_wr_en), 64'd0);
    end
    if (bus.in_rd_en) begin
      if (bus.in_empty) begin
        check("rd_while_empty", 64'(bus.in_empty), 64'd0);
      end else begin
        sb.push_back(model(src.pop_front()));
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 600 && (src.size() != 0 || sb.size() != 0); k++) step(1'b0);
    check("drain_empty", 64'(src.size() + sb.size()), 64'd0);
    step(1'b0);
    step(1'b0);
  endtask

  // Single vector through an empty pipe: bounded wait, latency and value
  task automatic push_and_expect(input string name, input vec_t v, input logic [DW-1:0] exp_out);
    int rd_c;
    int wr_c;
    bit got_rd;
    bit got_wr;
    got_rd = 1'b0;
    got_wr = 1'b0;
    rd_c   = 0;
    wr_c   = 0;
    src.push_back(v);
    for (int k = 0; k < 10 && !got_wr; k++) begin
      step(1'b0);
      if (bus.in_rd_en && !got_rd) begin
        got_rd = 1'b1;
        rd_c   = cyc;
      end
      if (bus.out_wr_en) begin
        got_wr = 1'b1;
        wr_c   = cyc;
      end
    end
    check({name, "_write_seen"}, 64'(got_wr), 64'd1);
    if (got_wr) begin
      check({name, "_latency"}, 64'(wr_c - rd_c), 64'd2);
      check({name, "_out"}, 64'(bus.out), 64'(exp_out));
    end
    drain();
  endtask

  // Monitor: every write must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    #2;
    if (bus.out_wr_en) begin
      check("wr_while_full", 64'(bus.out_full), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write out='h%0h expected no write (cycle %0d)", bus.out, cyc);
      end else begin
        e = sb.pop_front();
        check("sb_out", 64'(bus.out), 64'(e.out));
`ifdef DOT_PIPE_SATURATE_EN
        check("sb_sat_flag", 64'(bus.sat_flag), 64'(e.sat));
`endif
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    bit rd_s [14];
    bit wr_s [14];
    vec_t v;

    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    bus.x        = '0;
    bus.y        = '0;

    // Reset with data waiting upstream: nothing read or written
    src.push_back(mk_vec(5, 6, 7, 8, 9, 10));
    for (int k = 0; k < 3; k++) step(1'b1);
    sb.delete();
    step(1'b0);
    check("post_reset_out", 64'(bus.out), 64'd0);
    check("post_reset_wr", 64'(bus.out_wr_en), 64'd0);
    drain();

    // Directed arithmetic cases
    push_and_expect("basic", mk_vec(1024, 2048, 3072, 1024, 1024, 1024), 32'd6144);
    push_and_expect("sign", mk_vec(-1024, 1, -1, 512, 1, 1), -32'sd513);
`ifdef DOT_PIPE_SATURATE_EN
    push_and_expect("overflow", mk_vec(1 << 30, 1 << 30, 1 << 30, 1 << 30, 1 << 30, 1 << 30), 32'h7FFF_FFFF);
`else
    push_and_expect("overflow", mk_vec(1 << 30, 1 << 30, 1 << 30, 1 << 30, 1 << 30, 1 << 30), 32'h0000_0000);
`endif

    // Throughput: 8 back-to-back reads, 8 back-to-back writes two cycles later
    for (int k = 0; k < 8; k++) src.push_back(rand_vec());
    for (int k = 0; k < 14; k++) begin
      step(1'b0);
      rd_s[k] = bus.in_rd_en;
      wr_s[k] = bus.out_wr_en;
    end
    for (int k = 0; k < 14; k++) begin
      check($sformatf("tp_rd%0d", k), 64'(rd_s[k]), 64'(k < 8));
      check($sformatf("tp_wr%0d", k), 64'(wr_s[k]), 64'(k >= 2 && k < 10));
    end
    drain();

    // Backpressure with both stages full
    for (int k = 0; k < 4; k++) src.push_back(rand_vec());
    v = src[0];
    step(1'b0);
    step(1'b0);
    full_pct = 100;
    step(1'b0);
    held = bus.out;
    check("bp_held_value", 64'(held), 64'(model(v).out));
    check("bp_rd0", 64'(bus.in_rd_en), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      check("bp_rd", 64'(bus.in_rd_en), 64'd0);
      check("bp_wr", 64'(bus.out_wr_en), 64'd0);
      check("bp_out_stable", 64'(bus.out), 64'(held));
    end
    full_pct = 0;
    step(1'b0);
    check("bp_release_wr", 64'(bus.out_wr_en), 64'd1);
    check("bp_release_rd", 64'(bus.in_rd_en), 64'd1);
    step(1'b0);
    check("bp_release_wr2", 64'(bus.out_wr_en), 64'd1);
    drain();

    // Reset mid-stream: in-flight results must never appear
    for (int k = 0; k < 4; k++) src.push_back(rand_vec());
    step(1'b0);
    step(1'b0);
    step(1'b1);
    sb.delete();
    step(1'b0);
    check("mid_reset_out", 64'(bus.out), 64'd0);
    check("mid_reset_wr", 64'(bus.out_wr_en), 64'd0);
    drain();

    // Randomized traffic with bubbles and backpressure
    bubble_pct = 30;
    full_pct   = 30;
    for (int k = 0; k < 300; k++) src.push_back(rand_vec());
    drain();
    bubble_pct = 0;
    full_pct   = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dot_pipe.md
Name: dot_pipe

Overview:
- Parametrised, fully pipelined fixed-point dot product of two N-element signed vectors.
- Reads one operand pair per cycle from an upstream FIFO (in_empty/in_rd_en) and writes one result per cycle into a downstream FIFO (out_full/out_wr_en).
- Sustains throughput of 1 vector/cycle, unlike the two-state unpipelined dot unit.
- Drop-in for vector math stages of the ray tracer (normals, intersection tests).

Parameters:
- DATA_WIDTH, 32, width of each element and of the result (signed fixed point).
- Q_BITS, 10, fractional bits; each product is shifted right by Q_BITS.
- N, 3, vector length (channel count); legal range 1..16.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- x  in  N x DATA_WIDTH  signed operand vector, element i = x[i], valid when in_empty=0.
- y  in  N x DATA_WIDTH  signed operand vector.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pop upstream FIFO; operands consumed in the same cycle.
- out  out  DATA_WIDTH  signed result, drives downstream FIFO din.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  push out into downstream FIFO this cycle.

Behaviour:
- Reset: synchronous; on a clock edge with reset=1, all valid flags, product registers and out are cleared to 0. in_rd_en=0 and out_wr_en=0 while reset is high. Any in-flight data is discarded.
- Pipeline: two register stages.
  - Stage A holds N products p[i]=x[i]*y[i], each full 2*DATA_WIDTH signed, plus flag vA.
  - Stage B holds out plus flag vB.
- Control:
  - advance = !vB | !out_full.
  - in_rd_en = !in_empty & advance.
  - out_wr_en = vB & !out_full.
- On each edge with advance=1:
  - vA<=in_rd_en; stage A loads products only when in_rd_en=1.
  - vB<=vA; stage B loads the reduced sum when vA=1.
- advance=0: both stages hold; out is stable.
- Latency: operands read in cycle t -> out_wr_en=1 with matching out in cycle t+2, if out_full stays low.
- Arithmetic:
  - Each product is arithmetically shifted right by Q_BITS (floor toward -inf).
  - Shifted products are summed at width 2*DATA_WIDTH+clog2(N) with no intermediate overflow.
  - The sum is narrowed to DATA_WIDTH by two's-complement wrap (low bits), unless saturation is enabled.
- Boundary conditions:
  - Simultaneous in_empty=0 and out_full=1 with vB=1: no read, no write, hold.
  - out_full deasserting with vA=vB=1: write B, shift A->B and read a new input, all in the same cycle.
  - in_empty toggling creates bubbles (vA=0) that propagate; out_wr_en never asserts on a bubble.
  - in_rd_en and out_wr_en never depend combinationally on x, y.

Optional Feature:
- Macro DOT_PIPE_SATURATE_EN.
- Defined: the final narrowing clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Adds output port sat_flag (out, 1), which is registered with out, set when the clamp was applied, and reset to 0.
- Undefined: wrap truncation and no sat_flag port.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic: x=(1024,2048,3072), y=(1024,1024,1024) single push -> out_wr_en 2 cycles after in_rd_en, out=6144.
- Sign/rounding: x=(-1024,1,-1), y=(512,1,1) -> out = -512+0+(-1) = -513.
- Throughput: 8 vectors, in_empty=0, out_full=0 -> in_rd_en high 8 consecutive cycles, out_wr_en high 8 consecutive cycles starting 2 cycles later, results in order.
- Backpressure: out_full=1 for 3 cycles while vA=vB=1 -> in_rd_en=0, out held constant, no writes. On release, 2 writes on consecutive cycles with no loss or duplication.
- Overflow: x=y=(2^30,2^30,2^30) -> wrap build out=0; DOT_PIPE_SATURATE_EN build out=0x7FFFFFFF, sat_flag=1.
- Reset mid-stream: reset=1 for one cycle with vA=vB=1 -> next cycle out=0, out_wr_en=0, in_rd_en=0 during reset; pre-reset data never written.
